div_seq: RTL

Multi-cycle sequencer for the RV32M divide/remainder instructions (DIV, DIVU, REM, REMU) in the EXE stage. It accepts forwarded operands from the EXE operand muxes and runs a 32-iteration restoring divide. While it runs, it stalls IF/ID/EXE, then pulses `done` so the EXE/MEM register captures `result` in place of the ALU output. It is the only owner of the divide datapath and never touches the single-cycle ALU.

---
 rtl/exe_pkg.sv | 12 +
 rtl/div_step.sv | 29 ++
 rtl/div_seq.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/exe_pkg.sv
// Shared EXE-stage definitions: operand width, M-extension funct3 codes and
// the divide sequencer state encoding.
package exe_pkg;
  localparam int XLEN = 32;

  localparam logic [2:0] F3_DIV  = 3'b100;
  localparam logic [2:0] F3_DIVU = 3'b101;
  localparam logic [2:0] F3_REM  = 3'b110;
  localparam logic [2:0] F3_REMU = 3'b111;

  typedef enum logic [1:0] {DIV_IDLE, DIV_CALC, DIV_DONE} div_state_e;
endpackage

// File: rtl/div_step.sv
// One restoring-divide iteration: shift {rem, quo} left by one, trial-subtract
// the divisor magnitude from rem, keep or restore, and record the quotient bit.
module div_step
  import exe_pkg::*;
(
  input  logic [XLEN:0]   rem,
  input  logic [XLEN-1:0] quo,
  input  logic [XLEN-1:0] dvsr,
  output logic [XLEN:0]   rem_nxt,
  output logic [XLEN-1:0] quo_nxt
);

  logic [XLEN+1:0] sh;
  logic [XLEN+1:0] diff;

  // Shift in the next dividend bit, then test whether the divisor fits.
  always_comb begin
    sh   = {rem, quo[XLEN-1]};
    diff = sh - {2'b00, dvsr};
    if (!diff[XLEN+1]) begin
      rem_nxt = diff[XLEN:0];
      quo_nxt = {quo[XLEN-2:0], 1'b1};
    end else begin
      rem_nxt = sh[XLEN:0];
      quo_nxt = {quo[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_seq.sv
// RV32M DIV/DIVU/REM/REMU sequencer for EXE. Runs a 32-iteration restoring
// divide on operand magnitudes, stalls the front end while busy, and pulses
// done with the sign-corrected result.
// Optional: DIV_EARLY_OUT_EN finishes in one cycle when |dividend| < |divisor|.
module div_seq
  import exe_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1data,
  input  logic [XLEN-1:0] rs2data,
  input  logic            flush,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);

  div_state_e      state, state_nxt;
  logic [4:0]      cnt;
  logic [XLEN:0]   rem;
  logic [XLEN-1:0] quo;
  logic [XLEN-1:0] dvsr;
  logic [2:0]      f3;
  logic            neg_q, neg_r;
  logic [XLEN-1:0] res_q;

  logic [XLEN:0]   rem_nxt;
  logic [XLEN-1:0] quo_nxt;

  logic            sgn, a_neg, b_neg;
  logic [XLEN-1:0] abs_a, abs_b;
  logic            div0, ovf, early, fast, accept;
  logic [XLEN-1:0] q_fix, r_fix, fix_res;

  div_step u_step (
    .rem     (rem),
    .quo     (quo),
    .dvsr    (dvsr),
    .rem_nxt (rem_nxt),
    .quo_nxt (quo_nxt)
  );

  // Operand conditioning: magnitudes, sign flags and fast-path detection.
  always_comb begin
    sgn    = (funct3 == F3_DIV) || (funct3 == F3_REM);
    a_neg  = sgn & rs1data[XLEN-1];
    b_neg  = sgn & rs2data[XLEN-1];
    abs_a  = a_neg ? -rs1data : rs1data;
    abs_b  = b_neg ? -rs2data : rs2data;
    div0   = (rs2data == '0);
    ovf    = sgn && (rs1data == {1'b1, {(XLEN-1){1'b0}}}) && (rs2data == '1);
`ifdef DIV_EARLY_OUT_EN
    early  = !div0 && (abs_a < abs_b);
`else
    early  = 1'b0;
`endif
    fast   = div0 | ovf | early;
    accept = (state == DIV_IDLE) & start & ~flush;
  end

  // Sign fix-up of the raw magnitudes; special cases were preloaded so that
  // they pass through this same path.
  always_comb begin
    q_fix   = neg_q ? -quo : quo;
    r_fix   = neg_r ? -rem[XLEN-1:0] : rem[XLEN-1:0];
    fix_res = ((f3 == F3_REM) || (f3 == F3_REMU)) ? r_fix : q_fix;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= DIV_IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic; flush always returns to IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      DIV_IDLE: if (accept) state_nxt = fast ? DIV_DONE : DIV_CALC;
      DIV_CALC: if (cnt == 5'd0) state_nxt = DIV_DONE;
      DIV_DONE: state_nxt = DIV_IDLE;
      default:  state_nxt = DIV_IDLE;
    endcase
    if (flush) state_nxt = DIV_IDLE;
  end

  // Outputs: stall/done are suppressed by reset and flush in the same cycle.
  always_comb begin
    stall  = 1'b0;
    done   = 1'b0;
    result = '0;
    if (rst) begin
      if (!flush) begin
        stall = ((state == DIV_IDLE) & start) | (state == DIV_CALC);
        done  = (state == DIV_DONE);
      end
      result = done ? fix_res : res_q;
    end
  end

  // Working registers: operand latch on accept, one iteration per CALC
  // cycle, result capture on done.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt   <= '0;
      rem   <= '0;
      quo   <= '0;
      dvsr  <= '0;
      f3    <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      res_q <= '0;
    end else begin
      if (accept) begin
        f3   <= funct3;
        dvsr <= abs_b;
        cnt  <= fast ? 5'd0 : 5'd31;
        if (div0) begin
          quo   <= '1;
          rem   <= {1'b0, abs_a};
          neg_q <= 1'b0;
          neg_r <= a_neg;
        end else if (ovf) begin
          quo   <= {1'b1, {(XLEN-1){1'b0}}};
          rem   <= '0;
          neg_q <= 1'b0;
          neg_r <= 1'b0;
        end else if (early) begin
          quo   <= '0;
          rem   <= {1'b0, abs_a};
          neg_q <= 1'b0;
          neg_r <= a_neg;
        end else begin
          quo   <= abs_a;
          rem   <= '0;
          neg_q <= a_neg ^ b_neg;
          neg_r <= a_neg;
        end
      end else if ((state == DIV_CALC) && !flush) begin
        rem <= rem_nxt;
        quo <= quo_nxt;
        if (cnt != 5'd0) cnt <= cnt - 5'd1;
      end
      if (done) res_q <= fix_res;
    end
  end

endmodule
